// File: rtl/psum_writeback_pkg.sv
// Shared types and helpers for the partial-sum writeback stage.
// Holds the drain state encoding and the lane requantization function.
package psum_writeback_pkg;

  localparam logic WB_IDLE  = 1'b0;
  localparam logic WB_DRAIN = 1'b1;

  typedef enum logic {
    IDLE  = WB_IDLE,
    DRAIN = WB_DRAIN
  } wb_state_t;

  // Arithmetic (floor) shift, optional ReLU, then clamp to the signed output range.
  // Widths are passed in so one definition serves every lane/word size up to 64 bits.
  function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                 input int                 shift,
                                                 input int                 out_width,
                                                 input logic               relu);
    logic signed [63:0] y;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    y     = acc >>> shift;
    max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_width - 1));
    if (relu && (y < 64'sd0)) y = 64'sd0;
    if (y > max_v) y = max_v;
    else if (y < min_v) y = min_v;
    return y;
  endfunction

endpackage

// File: rtl/psum_writeback_requant.sv
// Single-lane requantizer: shift, optional ReLU and saturation, purely combinational.
import psum_writeback_pkg::*;

module psum_requant #(
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic                        relu_en,
  output logic signed [OUT_WIDTH-1:0] result
);

  assign result = OUT_WIDTH'(requant(64'(acc), SHIFT, OUT_WIDTH, relu_en));

endmodule

// File: rtl/psum_writeback.sv
// Captures the accumulator vector on each timestep strobe and drains it one
// requantized lane per cycle into the output memory at a wrapping address.
import psum_writeback_pkg::*;

module psum_writeback #(
  parameter int LANES      = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int SHIFT      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic                        relu_en,
  input  logic                        capture,
  input  logic                        last,
  input  logic [LANES*ACC_WIDTH-1:0]  acc_in,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [OUT_WIDTH-1:0]        mem_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  wb_state_t                    state;
  logic                         pend_done;
  logic [IDX_W-1:0]             idx;
  logic [IDX_W-1:0]             next_idx;
  logic [ADDR_WIDTH-1:0]        ptr;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic signed [ACC_WIDTH-1:0]  lane_q [LANES];
  logic                         relu_q;
  logic signed [ACC_WIDTH-1:0]  sel_acc;
  logic                         sel_relu;
  logic signed [OUT_WIDTH-1:0]  q;
  logic                         do_latch;
  logic                         do_write;

  assign next_idx = idx + IDX_W'(1);
  assign wr_addr  = (state == IDLE && start) ? base_addr : ptr;

  // Lane 0 of a fresh capture is written straight from acc_in, so the mux
  // bypasses the latch whenever a new timestep is being accepted.
  always_comb begin
    do_latch = capture && (state == IDLE || idx == LAST_IDX);
    do_write = do_latch || (state == DRAIN && idx != LAST_IDX);
    sel_acc  = acc_in[0 +: ACC_WIDTH];
    sel_relu = relu_en;
    if (state == DRAIN && idx != LAST_IDX) begin
      sel_acc  = lane_q[next_idx];
      sel_relu = relu_q;
    end
  end

  psum_requant #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_requant (
    .acc    (sel_acc),
    .relu_en(sel_relu),
    .result (q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pend_done <= 1'b0;
      idx       <= '0;
      ptr       <= '0;
      relu_q    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else begin
      done   <= 1'b0;
      mem_we <= do_write;
      if (state == IDLE && start) ptr <= base_addr;
      if (do_write) begin
        mem_addr  <= wr_addr;
        mem_wdata <= q;
        ptr       <= wr_addr + ADDR_WIDTH'(1);
      end
      if (do_latch) begin
        for (int i = 0; i < LANES; i++) lane_q[i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
        relu_q <= relu_en;
        idx    <= '0;
        state  <= DRAIN;
        busy   <= 1'b1;
      end else if (state == DRAIN) begin
        if (idx == LAST_IDX) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          idx <= next_idx;
        end
      end
      // A pending completion survives back-to-back captures and fires only
      // once the drain actually empties.
      if (state == IDLE) begin
        if (start) begin
          overflow  <= 1'b0;
          pend_done <= 1'b0;
        end
        if (last) begin
          if (capture) pend_done <= 1'b1;
          else done <= 1'b1;
        end
      end else begin
        if (capture && idx != LAST_IDX) overflow <= 1'b1;
        if (idx == LAST_IDX && !capture) begin
          done      <= pend_done | last;
          pend_done <= 1'b0;
        end else if (last) begin
          pend_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_writeback.sv
// Directed bench for psum_writeback: expected writes go into a scoreboard when a
// capture is driven and are popped and compared as the DUT writes them.
module tb_psum_writeback;

  localparam int LANES      = 8;
  localparam int ACC_WIDTH  = 24;
  localparam int OUT_WIDTH  = 16;
  localparam int ADDR_WIDTH = 10;
  localparam int SHIFT      = 8;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        start;
  logic [ADDR_WIDTH-1:0]       base_addr;
  logic                        relu_en;
  logic                        capture;
  logic                        last;
  logic [LANES*ACC_WIDTH-1:0]  acc_in;
  logic                        mem_we;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [OUT_WIDTH-1:0]        mem_wdata;
  logic                        busy;
  logic                        done;
  logic                        overflow;

  psum_writeback #(
    .LANES(LANES), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .relu_en(relu_en), .capture(capture), .last(last), .acc_in(acc_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                    cyc;
    logic [ADDR_WIDTH-1:0] addr;
    logic [OUT_WIDTH-1:0]  data;
  } wr_t;

  wr_t                   sb[$];
  wr_t                   mon_e;
  int                    checks = 0;
  int                    passes = 0;
  int                    fails = 0;
  int                    done_count = 0;
  int                    done_cyc = -1;
  logic [ADDR_WIDTH-1:0] exp_ptr = '0;
  logic [ACC_WIDTH-1:0]  stim [LANES];
  logic [OUT_WIDTH-1:0]  expv [LANES];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_WIDTH-1:0] model_q(input logic [ACC_WIDTH-1:0] a, input logic relu);
    int v;
    v = int'($signed(a));
    v = v >>> SHIFT;
    if (relu && v < 0) v = 0;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[OUT_WIDTH-1:0];
  endfunction

  // Monitor: every write must match the next scoreboard entry, including its cycle.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
    if (mem_we !== 1'b0) begin
      check_output("write_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check_output("write_cycle", 32'(cyc), 32'(mon_e.cyc));
        check_output("write_addr", 32'(mem_addr), 32'(mon_e.addr));
        check_output("write_data", 32'(mem_wdata), 32'(mon_e.data));
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_acc();
    for (int i = 0; i < LANES; i++) acc_in[i*ACC_WIDTH +: ACC_WIDTH] = stim[i];
  endtask

  task automatic fill_model(input logic relu);
    for (int i = 0; i < LANES; i++) expv[i] = model_q(stim[i], relu);
  endtask

  task automatic fill_random();
    for (int i = 0; i < LANES; i++) stim[i] = ACC_WIDTH'($urandom);
  endtask

  task automatic do_start(input logic [ADDR_WIDTH-1:0] addr);
    start     = 1'b1;
    base_addr = addr;
    exp_ptr   = addr;
    step();
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input logic relu, input logic lst, input int n_push);
    wr_t e;
    drive_acc();
    relu_en = relu;
    last    = lst;
    capture = 1'b1;
    for (int i = 0; i < n_push; i++) begin
      e.cyc  = cyc + 1 + i;
      e.addr = exp_ptr;
      e.data = expv[i];
      sb.push_back(e);
      exp_ptr = exp_ptr + ADDR_WIDTH'(1);
    end
    step();
    capture = 1'b0;
    last    = 1'b0;
  endtask

  int dc0;
  int cap_cyc;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; relu_en = 1'b0;
    capture = 1'b0; last = 1'b0; acc_in = '0;
    step(3);
    check_output("rst_mem_we", 32'(mem_we), 32'd0);
    check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_output("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    step();

    $display("[TB] basic drain");
    do_start(10'h010);
    for (int i = 0; i < LANES; i++) begin
      stim[i] = ACC_WIDTH'(i << 8);
      expv[i] = OUT_WIDTH'(i);
    end
    apply_stimulus(1'b0, 1'b0, LANES);
    check_output("basic_busy_first", 32'(busy), 32'd1);
    step(7);
    check_output("basic_busy_last", 32'(busy), 32'd1);
    step();
    check_output("basic_busy_after", 32'(busy), 32'd0);
    check_output("basic_we_after", 32'(mem_we), 32'd0);
    check_output("basic_addr_hold", 32'(mem_addr), 32'h017);
    check_output("basic_data_hold", 32'(mem_wdata), 32'd7);

    $display("[TB] requant edges");
    stim[0] = 24'h7FFFFF; stim[1] = 24'h800000; stim[2] = 24'hFFFF00; stim[3] = 24'h000100;
    stim[4] = 24'hFFFFFF; stim[5] = 24'h000080; stim[6] = 24'h012345; stim[7] = 24'hFF0000;
    expv[0] = 16'h7FFF; expv[1] = 16'h8000; expv[2] = 16'hFFFF; expv[3] = 16'h0001;
    expv[4] = 16'hFFFF; expv[5] = 16'h0000; expv[6] = 16'h0123; expv[7] = 16'hFF00;
    apply_stimulus(1'b0, 1'b0, LANES);
    step(9);
    expv[0] = 16'h7FFF; expv[1] = 16'h0000; expv[2] = 16'h0000; expv[3] = 16'h0001;
    expv[4] = 16'h0000; expv[5] = 16'h0000; expv[6] = 16'h0123; expv[7] = 16'h0000;
    apply_stimulus(1'b1, 1'b0, LANES);
    step(9);
    check_output("requant_idle", 32'(busy), 32'd0);

    $display("[TB] back-to-back with dropped capture");
    fill_random();
    fill_model(1'b0);
    apply_stimulus(1'b0, 1'b0, LANES);
    step(2);
    fill_random();
    drive_acc();
    capture = 1'b1;
    step();
    capture = 1'b0;
    check_output("drop_overflow_set", 32'(overflow), 32'd1);
    check_output("drop_busy", 32'(busy), 32'd1);
    step(4);
    fill_random();
    fill_model(1'b1);
    apply_stimulus(1'b1, 1'b0, LANES);
    step(8);
    check_output("b2b_busy_after", 32'(busy), 32'd0);
    check_output("b2b_overflow_sticky", 32'(overflow), 32'd1);

    $display("[TB] wrap and done");
    do_start(10'h3FC);
    check_output("start_clears_overflow", 32'(overflow), 32'd0);
    fill_random();
    fill_model(1'b0);
    apply_stimulus(1'b0, 1'b0, LANES);
    step(7);
    dc0 = done_count;
    fill_random();
    fill_model(1'b0);
    cap_cyc = cyc;
    apply_stimulus(1'b0, 1'b1, LANES);
    step(9);
    check_output("wrap_done_count", 32'(done_count - dc0), 32'd1);
    check_output("wrap_done_cycle", 32'(done_cyc), 32'(cap_cyc + LANES + 1));
    check_output("wrap_next_ptr", 32'(mem_addr), 32'h00B);

    $display("[TB] reset mid-drain");
    do_start(10'h040);
    dc0 = done_count;
    fill_random();
    fill_model(1'b0);
    apply_stimulus(1'b0, 1'b1, 4);
    step(3);
    reset = 1'b1;
    step();
    check_output("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check_output("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check_output("mid_rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_output("mid_rst_busy", 32'(busy), 32'd0);
    check_output("mid_rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    step(10);
    check_output("mid_rst_no_done", 32'(done_count), 32'(dc0));
    check_output("mid_rst_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] idle last and start while busy");
    dc0 = done_count;
    last = 1'b1;
    step();
    last = 1'b0;
    check_output("idle_last_done", 32'(done), 32'd1);
    step();
    check_output("idle_last_done_clears", 32'(done), 32'd0);
    check_output("idle_last_done_once", 32'(done_count), 32'(dc0 + 1));
    do_start(10'h100);
    fill_random();
    fill_model(1'b0);
    apply_stimulus(1'b0, 1'b0, LANES);
    step();
    start = 1'b1;
    base_addr = 10'h200;
    step();
    start = 1'b0;
    step(6);
    check_output("busy_start_idle", 32'(busy), 32'd0);
    fill_random();
    fill_model(1'b1);
    apply_stimulus(1'b1, 1'b0, LANES);
    step(9);

    check_output("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
